veririsc_controller: RTL and testbench

- Instruction sequencer for the VeriRISC CPU; sits directly upstream of the datapath registers (IR, AC, PC) and drives their load/increment strobes.
- Runs an internal 8-phase counter per instruction and decodes opcode/zero into memory, mux and register-load controls.
- Outputs are Moore/Mealy-decoded from the current phase and opcode, so a strobe such as ld_ac is valid for the cycle before the clock edge that loads the register.

---
 rtl/veririsc_pkg.sv | 40 ++++
 rtl/veririsc_phase_counter.sv | 26 ++
 rtl/veririsc_controller.sv | 129 ++++++++++++
 tb/tb_veririsc_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/veririsc_pkg.sv
// Shared definitions for the VeriRISC instruction sequencer.
// Holds the opcode encodings, the phase enumeration, the ISA width constants
// and small helpers shared by the controller and its phase counter.
// Optional build macro used by the controller: VERIRISC_CTRL_STEP_EN.
package veririsc_pkg;

  localparam int unsigned OPCODE_WIDTH = 3;
  localparam int unsigned PHASE_WIDTH  = 3;

  localparam logic [OPCODE_WIDTH-1:0] HLT = 3'd0;
  localparam logic [OPCODE_WIDTH-1:0] SKZ = 3'd1;
  localparam logic [OPCODE_WIDTH-1:0] ADD = 3'd2;
  localparam logic [OPCODE_WIDTH-1:0] AND = 3'd3;
  localparam logic [OPCODE_WIDTH-1:0] XOR = 3'd4;
  localparam logic [OPCODE_WIDTH-1:0] LDA = 3'd5;
  localparam logic [OPCODE_WIDTH-1:0] STO = 3'd6;
  localparam logic [OPCODE_WIDTH-1:0] JMP = 3'd7;

  typedef enum logic [PHASE_WIDTH-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // STORE + 1 wraps to INST_ADDR through the natural 3-bit overflow.
  function automatic phase_t next_phase(input phase_t p);
    return phase_t'(p + 3'd1);
  endfunction

  // Instructions that read an operand and load the accumulator.
  function automatic logic is_aluop(input logic [OPCODE_WIDTH-1:0] op);
    return op inside {ADD, AND, XOR, LDA};
  endfunction

endpackage

// File: rtl/veririsc_phase_counter.sv
// Eight-phase instruction counter for the VeriRISC sequencer.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset, forces INST_ADDR
//   ena   - advance enable
//   hold  - freezes the phase even when enabled (halt / single-step gating)
//   phase - current phase
module veririsc_phase_counter
  import veririsc_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   ena,
  input  logic   hold,
  output phase_t phase
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= INST_ADDR;
    end else if (ena && !hold) begin
      phase <= next_phase(phase);
    end
  end

endmodule

// File: rtl/veririsc_controller.sv
// VeriRISC instruction sequencer: steps an 8-phase counter per instruction
// and decodes phase/opcode/zero into memory, address-mux and register-load
// strobes for the IR, AC and PC datapath registers. Strobes are decoded
// combinationally so each is valid in the cycle before the loading edge.
// Build option: VERIRISC_CTRL_STEP_EN adds a single-step handshake that
// holds STORE until step=1.
// Ports:
//   clk, rst (async active-low), ena (phase advance enable)
//   opcode, zero       - IR opcode and accumulator-is-zero flag
//   step, step_wait    - single-step request/wait (VERIRISC_CTRL_STEP_EN only)
//   sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e - datapath controls
//   halt               - sticky halted flag, cleared only by rst
//   phase              - current phase for debug
module veririsc_controller
  import veririsc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
`ifdef VERIRISC_CTRL_STEP_EN
  input  logic                    step,
  output logic                    step_wait,
`endif
  output logic                    sel,
  output logic                    rd,
  output logic                    ld_ir,
  output logic                    inc_pc,
  output logic                    ld_pc,
  output logic                    ld_ac,
  output logic                    wr,
  output logic                    data_e,
  output logic                    halt,
  output logic [PHASE_WIDTH-1:0]  phase
);

  phase_t phase_q;
  logic   halt_q;
  logic   hlt_seen;
  logic   store_wait;
  logic   hold;
  logic   aluop;

  assign hlt_seen = !halt_q && (phase_q == OP_ADDR) && (opcode == HLT);

`ifdef VERIRISC_CTRL_STEP_EN
  assign store_wait = (phase_q == STORE) && !step;
  assign step_wait  = store_wait;
`else
  assign store_wait = 1'b0;
`endif

  // HLT is caught while still in OP_ADDR so the phase never leaves it.
  assign hold = halt_q | hlt_seen | store_wait;

  veririsc_phase_counter u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .hold  (hold),
    .phase (phase_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_q <= 1'b0;
    end else if (ena && hlt_seen) begin
      halt_q <= 1'b1;
    end
  end

  assign aluop = is_aluop(opcode);
  assign halt  = halt_q;
  assign phase = phase_q;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (!halt_q) begin
      case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = (opcode != HLT);
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          // A STORE waiting on step keeps every strobe low so wr/ld_ac fire once.
          if (!store_wait) begin
            rd     = aluop;
            ld_ac  = aluop;
            ld_pc  = (opcode == JMP);
            wr     = (opcode == STO);
            data_e = (opcode == STO);
          end
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_veririsc_controller.sv
// Self-checking bench for veririsc_controller. A reference model predicts the
// full output vector for each cycle; predictions are queued as stimulus is
// driven and popped when the outputs are sampled after the falling edge.
module tb_veririsc_controller;

  typedef logic [11:0] vec_t;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       step_v;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;
`ifdef VERIRISC_CTRL_STEP_EN
  logic       step_wait;
`endif

  int vectors;
  int miscompares;

  vec_t sb[$];
  vec_t exp_v;
  vec_t got_v;

  logic [2:0] m_phase;
  logic       m_halt;

  veririsc_controller dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .opcode    (opcode),
    .zero      (zero),
`ifdef VERIRISC_CTRL_STEP_EN
    .step      (step_v),
    .step_wait (step_wait),
`endif
    .sel       (sel),
    .rd        (rd),
    .ld_ir     (ld_ir),
    .inc_pc    (inc_pc),
    .ld_pc     (ld_pc),
    .ld_ac     (ld_ac),
    .wr        (wr),
    .data_e    (data_e),
    .halt      (halt),
    .phase     (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t observed();
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase};
  endfunction

  // Reference decode: {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase}
  function automatic vec_t model(input logic [2:0] ph, input logic hl,
                                 input logic [2:0] op, input logic z,
                                 input logic st);
    logic [7:0] s;
    logic alu;
    alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    s = 8'b0;
    if (!hl) begin
      case (ph)
        3'd0: s = 8'b1000_0000;
        3'd1: s = 8'b1100_0000;
        3'd2: s = 8'b1110_0000;
        3'd3: s = 8'b1110_0000;
        3'd4: s = {3'b000, op != 3'd0, 4'b0000};
        3'd5: s = {1'b0, alu, 6'b0};
        3'd6: s = {1'b0, alu, 1'b0, (op == 3'd1) && z, op == 3'd7, 2'b00, op == 3'd6};
        default: s = st ? {1'b0, alu, 2'b00, op == 3'd7, alu, op == 3'd6, op == 3'd6} : 8'b0;
      endcase
    end
    return {s, hl, ph};
  endfunction

  task automatic drive(input logic e, input logic [2:0] op, input logic z, input logic st);
    @(negedge clk);
    ena    = e;
    opcode = op;
    zero   = z;
    step_v = st;
    sb.push_back(model(m_phase, m_halt, op, z, st));
  endtask

  task automatic tick();
    @(posedge clk);
    if (ena && !m_halt) begin
      if (m_phase == 3'd4 && opcode == 3'd0) m_halt = 1'b1;
`ifdef VERIRISC_CTRL_STEP_EN
      else if (m_phase == 3'd7 && !step_v) m_halt = 1'b0;
`endif
      else m_phase = m_phase + 3'd1;
    end
  endtask

  task automatic test_reset();
    ena = 1'b0;
    rst = 1'b0;
    m_phase = 3'd0;
    m_halt = 1'b0;
    sb.push_back(model(3'd0, 1'b0, opcode, zero, 1'b1));
    #2;
    exp_v = sb.pop_front();
    got_v = observed();
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL reset: got %b want %b", got_v, exp_v);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_opcode(input string name, input logic [2:0] op, input logic z, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, op, z, 1'b1);
      #1;
      exp_v = sb.pop_front();
      got_v = observed();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL %s cyc %0d: got %b want %b", name, i, got_v, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_hlt();
    for (int i = 0; i < 25; i++) begin
      drive(1'b1, 3'd0, 1'b0, 1'b1);
      #1;
      exp_v = sb.pop_front();
      got_v = observed();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL hlt cyc %0d: got %b want %b", i, got_v, exp_v);
      end
      tick();
    end
    @(negedge clk);
    ena = 1'b0;
    rst = 1'b0;
    m_phase = 3'd0;
    m_halt = 1'b0;
    sb.push_back(model(3'd0, 1'b0, opcode, zero, 1'b1));
    #1;
    exp_v = sb.pop_front();
    got_v = observed();
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL hlt_reset: got %b want %b", got_v, exp_v);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ena();
    // two cycles to reach INST_LOAD, five held cycles, then finish the instruction
    for (int i = 0; i < 13; i++) begin
      drive((i < 2 || i > 6), 3'd2, 1'b0, 1'b1);
      #1;
      exp_v = sb.pop_front();
      got_v = observed();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL ena cyc %0d: got %b want %b", i, got_v, exp_v);
      end
      if (i >= 2 && i <= 6 && (phase !== 3'd2 || ld_ir !== 1'b1)) begin
        miscompares++;
        $display("FAIL ena_hold cyc %0d: got phase %0d ld_ir %b want phase 2 ld_ir 1", i, phase, ld_ir);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'd6, 1'b0, 1'b1);
      #1;
      exp_v = sb.pop_front();
      got_v = observed();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL sto_pre cyc %0d: got %b want %b", i, got_v, exp_v);
      end
      if (i < 7) tick();
    end
    // now mid phase 7 with wr=1; reset well before the next rising edge
    #1;
    ena = 1'b0;
    rst = 1'b0;
    m_phase = 3'd0;
    m_halt = 1'b0;
    sb.push_back(model(3'd0, 1'b0, 3'd6, 1'b0, 1'b1));
    #1;
    exp_v = sb.pop_front();
    got_v = observed();
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL async_reset: got %b want %b", got_v, exp_v);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

`ifdef VERIRISC_CTRL_STEP_EN
  task automatic test_step();
    // seven cycles to STORE, three waiting, one stepped, then INST_ADDR
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 3'd2, 1'b0, (i < 7 || i == 10));
      #1;
      exp_v = sb.pop_front();
      got_v = observed();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL step cyc %0d: got %b want %b", i, got_v, exp_v);
      end
      vectors++;
      if (step_wait !== (m_phase == 3'd7 && !step_v)) begin
        miscompares++;
        $display("FAIL step_wait cyc %0d: got %b want %b", i, step_wait, (m_phase == 3'd7 && !step_v));
      end
      tick();
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    ena = 1'b0;
    opcode = 3'd2;
    zero = 1'b0;
    step_v = 1'b1;
    m_phase = 3'd0;
    m_halt = 1'b0;
    #1;
    test_reset();
    test_opcode("add_free_run", 3'd2, 1'b0, 9);
    test_opcode("sto", 3'd6, 1'b0, 7);
    test_opcode("skz_z1", 3'd1, 1'b1, 8);
    test_opcode("skz_z0", 3'd1, 1'b0, 8);
    test_opcode("jmp", 3'd7, 1'b0, 8);
    test_opcode("and_xor", 3'd3, 1'b1, 8);
    test_opcode("lda", 3'd5, 1'b0, 8);
    test_opcode("xor", 3'd4, 1'b0, 8);
    test_hlt();
    test_ena();
    test_async_reset();
`ifdef VERIRISC_CTRL_STEP_EN
    test_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
